wb_master_seq: RTL and testbench



---
 rtl/wb_master_seq.sv | 146 ++++++++++++++
 tb/tb_wb_master_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wb_master_seq                                                     |
// | Wishbone classic single-transaction master with cmd/rsp handshakes.        |
// | Optional bus watchdog: define WB_MASTER_TIMEOUT_EN.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_master_seq #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  sys_clk,
  input  logic                  RSTB,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_W-1:0]     cmd_adr,
  input  logic [DATA_W-1:0]     cmd_dat,
  input  logic [DATA_W/8-1:0]   cmd_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_dat,
  output logic                  rsp_err,
  output logic                  mgmtsoc_wishbone_cyc,
  output logic                  mgmtsoc_wishbone_stb,
  output logic                  mgmtsoc_wishbone_we,
  output logic [ADDR_W-1:0]     mgmtsoc_wishbone_adr,
  output logic [DATA_W-1:0]     mgmtsoc_wishbone_dat_w,
  output logic [DATA_W/8-1:0]   mgmtsoc_wishbone_sel,
  input  logic [DATA_W-1:0]     mgmtsoc_wishbone_dat_r,
  input  logic                  mgmtsoc_wishbone_ack,
  input  logic                  mgmtsoc_wishbone_err,
  output logic [15:0]           txn_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  generate
    if ((DATA_W % 8) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
      $error("wb_master_seq: illegal DATA_W or TIMEOUT");
    end
  endgenerate

  state_t                r_state;
  logic                  r_cyc;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_adr;
  logic [DATA_W-1:0]     r_dat_w;
  logic [DATA_W/8-1:0]   r_sel;
  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_dat;
  logic                  r_rsp_err;
  logic [15:0]           r_txn_count;
  logic                  w_done;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0]   c_WDOG_LAST = 16'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] c_TO_DAT = {DATA_W/4{4'hE}};
  logic [15:0]           r_wdog;
`endif

  assign w_done = mgmtsoc_wishbone_ack | mgmtsoc_wishbone_err;

  always_ff @(posedge sys_clk or negedge RSTB) begin
    if (!RSTB) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat_w     <= '0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_txn_count <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      r_wdog      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_we    <= cmd_we;
            r_adr   <= cmd_adr;
            r_dat_w <= cmd_dat;
            r_sel   <= cmd_sel;
            r_cyc   <= 1'b1;
            r_state <= S_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
            r_wdog  <= '0;
`endif
          end
        end
        S_BUS: begin
          // err outranks ack; writes never return bus data
          if (w_done) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= mgmtsoc_wishbone_err;
            r_rsp_dat   <= (r_we | mgmtsoc_wishbone_err) ? '0 : mgmtsoc_wishbone_dat_r;
            r_txn_count <= r_txn_count + 16'd1;
            r_state     <= S_RESP;
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (r_wdog == c_WDOG_LAST) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_dat   <= c_TO_DAT;
            r_txn_count <= r_txn_count + 16'd1;
            r_state     <= S_RESP;
          end else begin
            r_wdog      <= r_wdog + 16'd1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready              = (r_state == S_IDLE);
  assign rsp_valid              = r_rsp_valid;
  assign rsp_dat                = r_rsp_dat;
  assign rsp_err                = r_rsp_err;
  assign mgmtsoc_wishbone_cyc   = r_cyc;
  assign mgmtsoc_wishbone_stb   = r_cyc;
  assign mgmtsoc_wishbone_we    = r_we;
  assign mgmtsoc_wishbone_adr   = r_adr;
  assign mgmtsoc_wishbone_dat_w = r_dat_w;
  assign mgmtsoc_wishbone_sel   = r_sel;
  assign txn_count              = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_wb_master_seq                                                  |
// | Directed vector bench for wb_master_seq (WB_MASTER_TIMEOUT_EN optional).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wb_master_seq;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          sys_clk = 1'b0;
  logic          RSTB = 1'b1;
  logic          cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [DW-1:0] cmd_dat = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] dat_r = '0;
  logic          ack = 1'b0, err = 1'b0;
  logic          cmd_ready, rsp_valid, rsp_err, cyc, stb, we;
  logic [DW-1:0] rsp_dat, dat_w;
  logic [AW-1:0] adr;
  logic [SW-1:0] sel;
  logic [15:0]   txn_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  wb_master_seq #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .RSTB(RSTB),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .mgmtsoc_wishbone_cyc(cyc), .mgmtsoc_wishbone_stb(stb), .mgmtsoc_wishbone_we(we),
    .mgmtsoc_wishbone_adr(adr), .mgmtsoc_wishbone_dat_w(dat_w), .mgmtsoc_wishbone_sel(sel),
    .mgmtsoc_wishbone_dat_r(dat_r), .mgmtsoc_wishbone_ack(ack), .mgmtsoc_wishbone_err(err),
    .txn_count(txn_count)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "bench hung");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat_r;
    logic          ack;
    logic          err;
    int            dly;
    int            bp;
    logic [DW-1:0] exp_dat;
    logic          exp_err;
  } vec_t;

  vec_t vecs[7];

  // Called just after a negedge with the DUT idle.
  task automatic run_vec(input vec_t v);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    chk("cyc_start", cyc, 1);
    chk("stb_start", stb, 1);
    chk("bus_we", we, v.we);
    chk("bus_adr", adr, v.adr);
    chk("bus_dat_w", dat_w, v.dat);
    chk("bus_sel", sel, v.sel);
    chk("cmd_ready_bus", cmd_ready, 0);
    for (int k = 1; k <= v.dly; k++) begin
      if (k == v.dly) begin ack = v.ack; err = v.err; dat_r = v.dat_r; end
      @(negedge sys_clk);
      if (k < v.dly) chk("cyc_hold", cyc, 1);
    end
    ack = 1'b0; err = 1'b0; dat_r = 32'hDEAD_0000;
    exp_cnt++;
    chk("cyc_after_ack", cyc, 0);
    chk("stb_after_ack", stb, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_dat", rsp_dat, v.exp_dat);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("txn_count", txn_count, 16'(exp_cnt));
    for (int k = 0; k < v.bp; k++) begin
      @(negedge sys_clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_dat", rsp_dat, v.exp_dat);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_cyc", cyc, 0);
    end
    rsp_ready = 1'b1;
    @(negedge sys_clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    chk("cyc_idle", cyc, 0);
    chk("adr_hold", adr, v.adr);
    chk("sel_hold", sel, v.sel);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    @(negedge sys_clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int hi;
    logic bad;
    vecs[0] = '{1'b0, 30'h100,        32'h0,         4'hF, 32'hA5A5_1234, 1'b1, 1'b0, 2, 0, 32'hA5A5_1234, 1'b0};
    vecs[1] = '{1'b1, 30'h3FFF_FFFF,  32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 1, 0, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 30'h4,          32'h0,         4'hF, 32'h0000_00FF, 1'b1, 1'b0, 1, 0, 32'h0000_00FF, 1'b0};
    vecs[3] = '{1'b0, 30'h2AAA_AAAA,  32'h0,         4'h3, 32'h0BAD_F00D, 1'b1, 1'b0, 3, 5, 32'h0BAD_F00D, 1'b0};
    vecs[4] = '{1'b0, 30'h1555_5555,  32'h0,         4'hF, 32'hFFFF_FFFF, 1'b1, 1'b1, 2, 0, 32'h0,         1'b1};
    vecs[5] = '{1'b1, 30'h40,         32'h5A5A_5A5A, 4'h9, 32'h7777_7777, 1'b0, 1'b1, 1, 2, 32'h0,         1'b1};
    vecs[6] = '{1'b0, 30'h0,          32'h0,         4'h1, 32'h8000_0001, 1'b1, 1'b0, 1, 0, 32'h8000_0001, 1'b0};

    // Reset values
    #2 RSTB = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat_w", dat_w, 0);
    chk("rst_sel", sel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_txn_count", txn_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    RSTB = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Command held across the response handshake is only taken one edge later
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 30'h55; cmd_sel = 4'hF;
    @(negedge sys_clk);
    cmd_valid = 1'b0; ack = 1'b1; dat_r = 32'h0000_0011;
    @(negedge sys_clk);
    ack = 1'b0; exp_cnt++;
    chk("hs_rsp_dat", rsp_dat, 32'h11);
    ack = 1'b1; err = 1'b1;  // stray while in RESP
    @(negedge sys_clk);
    ack = 1'b0; err = 1'b0;
    chk("stray_resp_count", txn_count, 16'(exp_cnt));
    chk("stray_resp_dat", rsp_dat, 32'h11);
    chk("stray_resp_err", rsp_err, 0);
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_adr = 30'h66;
    @(negedge sys_clk);
    rsp_ready = 1'b0;
    chk("hs_no_accept_cyc", cyc, 0);
    chk("hs_rsp_valid", rsp_valid, 0);
    chk("hs_adr_old", adr, 30'h55);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    chk("hs_accept_cyc", cyc, 1);
    chk("hs_accept_adr", adr, 30'h66);
    ack = 1'b1; dat_r = 32'h0000_0022;
    @(negedge sys_clk);
    ack = 1'b0; exp_cnt++;
    chk("hs2_rsp_dat", rsp_dat, 32'h22);
    drain();
    // Stray ack in IDLE
    ack = 1'b1;
    @(negedge sys_clk);
    ack = 1'b0;
    chk("stray_idle_count", txn_count, 16'(exp_cnt));
    chk("stray_idle_valid", rsp_valid, 0);
    chk("stray_idle_cyc", cyc, 0);

    // Silent slave
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 30'h77;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    hi = cyc ? 1 : 0;
`ifdef WB_MASTER_TIMEOUT_EN
    repeat (7) begin @(negedge sys_clk); if (cyc) hi++; end
    @(negedge sys_clk);
    exp_cnt++;
    chk("to_cyc_cycles", hi, 8);
    chk("to_cyc_drop", cyc, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_dat", rsp_dat, 32'hEEEE_EEEE);
    chk("to_txn_count", txn_count, 16'(exp_cnt));
    drain();
    // ack on the timeout edge wins
    cmd_valid = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge sys_clk);
    ack = 1'b1; dat_r = 32'h0000_1234;
    @(negedge sys_clk);
    ack = 1'b0; exp_cnt++;
    chk("to_ack_prio_err", rsp_err, 0);
    chk("to_ack_prio_dat", rsp_dat, 32'h1234);
    chk("to_ack_prio_count", txn_count, 16'(exp_cnt));
    drain();
`else
    repeat (99) begin @(negedge sys_clk); if (cyc) hi++; end
    chk("no_to_cyc_cycles", hi, 100);
    chk("no_to_rsp_valid", rsp_valid, 0);
    ack = 1'b1; dat_r = 32'h0000_0033;
    @(negedge sys_clk);
    ack = 1'b0; exp_cnt++;
    chk("no_to_rsp_dat", rsp_dat, 32'h33);
    chk("no_to_count", txn_count, 16'(exp_cnt));
    drain();
`endif

    // Reset in the middle of BUS
    cmd_valid = 1'b1; cmd_adr = 30'h99;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    chk("mid_rst_bus", cyc, 1);
    #2 RSTB = 1'b0;
    #1;
    chk("mid_rst_cyc", cyc, 0);
    chk("mid_rst_stb", stb, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_count", txn_count, 0);
    @(negedge sys_clk);
    RSTB = 1'b1;
    bad = 1'b0;
    ack = 1'b1;
    repeat (5) begin
      @(negedge sys_clk);
      ack = 1'b0;
      if (rsp_valid || cyc || !cmd_ready) bad = 1'b1;
    end
    chk("post_rst_quiet", bad, 0);
    chk("post_rst_count", txn_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
